// File: rtl/mult_issue_arbiter.sv
// -----------------------------------------------------------------------------
// mult_issue_arbiter
//
// Shares one pipelined MULT execution unit between N_REQ reservation-station
// requesters. Each cycle one requester is selected and its operands are
// forwarded to the MULT. A credit counter caps the number of issued but
// unreturned ops, so the MULT output spill cell can never overflow. A tag FIFO
// records the issuing requester of every op so that each in-order MULT result
// is routed back to the requester that issued it.
//
// Optional feature macro: MULT_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority arbitration, lowest index wins (no rr pointer)
//   undefined -> round-robin arbitration starting from rr_ptr (default)
//   The grant lock during a MULT stall applies in both modes.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i             pipeline flush (drops all in-flight bookkeeping)
//   req_valid_i/ready_o per-requester issue handshake
//   req_ctl_i, req_rob_idx_i, req_rs1_i, req_rs2_i
//                       per-requester operands, packed requester 0 in the LSBs
//   rsp_valid_o/ready_i per-requester result handshake
//   rsp_rob_idx_o, rsp_result_o, rsp_except_o
//                       shared result bus toward the requesters
//   mu_valid_o/ready_i  issue handshake toward the MULT
//   mu_ctl_o, mu_rob_idx_o, mu_rs1_o, mu_rs2_o
//                       operands of the granted requester
//   mu_valid_i/ready_o  result handshake from the MULT
//   mu_rob_idx_i, mu_result_i, mu_except_i
//                       MULT result fields
//   mu_flush_o          flush forwarded to the MULT pipeline
//
// Parameters
//   N_REQ        number of requesters (>= 2)
//   MAX_INFLIGHT credit limit and tag FIFO depth (power of 2, >= 2)
//   EU_CTL_LEN   MULT control field width
//   XLEN         data width
//   ROB_IDX_LEN  ROB index width
// -----------------------------------------------------------------------------
module mult_issue_arbiter #(
    parameter int N_REQ        = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int EU_CTL_LEN   = 4,
    parameter int XLEN         = 64,
    parameter int ROB_IDX_LEN  = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,

    input  logic [N_REQ-1:0]              req_valid_i,
    output logic [N_REQ-1:0]              req_ready_o,
    input  logic [N_REQ*EU_CTL_LEN-1:0]   req_ctl_i,
    input  logic [N_REQ*ROB_IDX_LEN-1:0]  req_rob_idx_i,
    input  logic [N_REQ*XLEN-1:0]         req_rs1_i,
    input  logic [N_REQ*XLEN-1:0]         req_rs2_i,

    output logic [N_REQ-1:0]              rsp_valid_o,
    input  logic [N_REQ-1:0]              rsp_ready_i,
    output logic [ROB_IDX_LEN-1:0]        rsp_rob_idx_o,
    output logic [XLEN-1:0]               rsp_result_o,
    output logic                          rsp_except_o,

    output logic                          mu_valid_o,
    input  logic                          mu_ready_i,
    output logic [EU_CTL_LEN-1:0]         mu_ctl_o,
    output logic [ROB_IDX_LEN-1:0]        mu_rob_idx_o,
    output logic [XLEN-1:0]               mu_rs1_o,
    output logic [XLEN-1:0]               mu_rs2_o,

    input  logic                          mu_valid_i,
    output logic                          mu_ready_o,
    input  logic [ROB_IDX_LEN-1:0]        mu_rob_idx_i,
    input  logic [XLEN-1:0]               mu_result_i,
    input  logic                          mu_except_i,

    output logic                          mu_flush_o
);

    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [ID_W-1:0]  tag_q [MAX_INFLIGHT];
    logic             lock_q;
    logic [ID_W-1:0]  lock_id_q;

    logic             active;
    logic             can_issue;
    logic             fifo_empty;
    logic             issue_hs;
    logic             ret_valid;
    logic             ret_hs;
    logic [ID_W-1:0]  pick;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  head_id;

    // Reset and flush both silence every handshake combinationally, so the
    // MULT and the requesters never see a transfer that would be lost.
    assign active     = !rst_i && !flush_i;
    assign fifo_empty = (count_q == '0);
    assign can_issue  = active && (count_q < CNT_W'(MAX_INFLIGHT));
    assign head_id    = tag_q[rd_ptr_q];
    assign mu_flush_o = flush_i;

`ifdef MULT_ARB_FIXED_PRIO_EN
    // Fixed priority: scanning from the top down leaves the lowest valid
    // index as the final pick.
    always_comb begin
        pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                pick = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr_q;

    // Round-robin search starting at rr_ptr and wrapping modulo N_REQ. The
    // index is wrapped by subtraction so non power-of-2 N_REQ also works.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                input logic [ID_W-1:0]  start);
        logic [ID_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(start) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && valid[ID_W'(idx)]) begin
                sel   = ID_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Rotating pick for the current cycle.
    always_comb begin
        pick = rr_pick(req_valid_i, rr_ptr_q);
    end

    // The pointer only advances on an accepted issue, so a stalled grant
    // leaves the rotation order untouched. Flush deliberately keeps it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else if (issue_hs) begin
            rr_ptr_q <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
        end
    end
`endif

    // While the MULT stalls an offered op, the grant stays on the same
    // requester so the operands presented to the MULT cannot change.
    assign winner     = lock_q ? lock_id_q : pick;
    assign mu_valid_o = can_issue && (|req_valid_i);
    assign issue_hs   = mu_valid_o && mu_ready_i;

    // Granted operands; zero when nothing is offered so the bus is quiet in
    // reset and flush.
    always_comb begin
        mu_ctl_o     = '0;
        mu_rob_idx_o = '0;
        mu_rs1_o     = '0;
        mu_rs2_o     = '0;
        if (mu_valid_o) begin
            mu_ctl_o     = req_ctl_i[winner*EU_CTL_LEN +: EU_CTL_LEN];
            mu_rob_idx_o = req_rob_idx_i[winner*ROB_IDX_LEN +: ROB_IDX_LEN];
            mu_rs1_o     = req_rs1_i[winner*XLEN +: XLEN];
            mu_rs2_o     = req_rs2_i[winner*XLEN +: XLEN];
        end
    end

    // Return path: the FIFO head names the requester that owns the oldest
    // in-flight op, which is exactly the result the in-order MULT returns.
    assign ret_valid  = active && mu_valid_i && !fifo_empty;
    assign mu_ready_o = active && !fifo_empty && rsp_ready_i[head_id];
    assign ret_hs     = ret_valid && mu_ready_o;

    // Shared result bus, zero unless a result is actually being offered.
    always_comb begin
        rsp_rob_idx_o = '0;
        rsp_result_o  = '0;
        rsp_except_o  = 1'b0;
        if (ret_valid) begin
            rsp_rob_idx_o = mu_rob_idx_i;
            rsp_result_o  = mu_result_i;
            rsp_except_o  = mu_except_i;
        end
    end

    // One-hot decode of the issue acknowledge and the result valid.
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (issue_hs && (winner == ID_W'(i))) begin
                req_ready_o[i] = 1'b1;
            end
            if (ret_valid && (head_id == ID_W'(i))) begin
                rsp_valid_o[i] = 1'b1;
            end
        end
    end

    // Credit counter and tag FIFO. The counter doubles as the FIFO
    // occupancy, so a freed credit is only visible the cycle after the
    // return (no same-cycle bypass into can_issue).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                tag_q[i] <= '0;
            end
        end else if (flush_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (issue_hs) begin
                tag_q[wr_ptr_q] <= winner;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (ret_hs) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({issue_hs, ret_hs})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Grant lock: armed when an offered op is not taken, released on the
    // accepting handshake or a flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else if (flush_i || issue_hs) begin
            lock_q    <= 1'b0;
        end else if (mu_valid_o) begin
            lock_q    <= 1'b1;
            lock_id_q <= winner;
        end
    end

    // A MULT result with no recorded owner means the MULT and this arbiter
    // disagree on what is in flight.
    p_no_orphan_result: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mu_valid_i && fifo_empty && !flush_i));

endmodule

// File: tb/tb_mult_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_issue_arbiter
//
// Self-checking bench for mult_issue_arbiter with N_REQ=2, MAX_INFLIGHT=4.
// The bench plays both the requesters and the MULT. Every accepted issue
// pushes the expected owner and the expected product into scoreboard queues;
// results are returned in order and checked against the popped entries.
// -----------------------------------------------------------------------------
module tb_mult_issue_arbiter;

    localparam int N_REQ        = 2;
    localparam int MAX_INFLIGHT = 4;
    localparam int EU_CTL_LEN   = 4;
    localparam int XLEN         = 64;
    localparam int ROB_IDX_LEN  = 5;

    logic                          clk_i = 1'b0;
    logic                          rst_i;
    logic                          flush_i;
    logic [N_REQ-1:0]              req_valid_i;
    logic [N_REQ-1:0]              req_ready_o;
    logic [N_REQ*EU_CTL_LEN-1:0]   req_ctl_i;
    logic [N_REQ*ROB_IDX_LEN-1:0]  req_rob_idx_i;
    logic [N_REQ*XLEN-1:0]         req_rs1_i;
    logic [N_REQ*XLEN-1:0]         req_rs2_i;
    logic [N_REQ-1:0]              rsp_valid_o;
    logic [N_REQ-1:0]              rsp_ready_i;
    logic [ROB_IDX_LEN-1:0]        rsp_rob_idx_o;
    logic [XLEN-1:0]               rsp_result_o;
    logic                          rsp_except_o;
    logic                          mu_valid_o;
    logic                          mu_ready_i;
    logic [EU_CTL_LEN-1:0]         mu_ctl_o;
    logic [ROB_IDX_LEN-1:0]        mu_rob_idx_o;
    logic [XLEN-1:0]               mu_rs1_o;
    logic [XLEN-1:0]               mu_rs2_o;
    logic                          mu_valid_i;
    logic                          mu_ready_o;
    logic [ROB_IDX_LEN-1:0]        mu_rob_idx_i;
    logic [XLEN-1:0]               mu_result_i;
    logic                          mu_except_i;
    logic                          mu_flush_o;

    typedef struct packed {
        logic [ROB_IDX_LEN-1:0] rob;
        logic [XLEN-1:0]        res;
    } mres_t;

    int    exp_tag_q[$];
    mres_t mult_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    model_rr = 0;
    int    op_seed  = 0;

    mult_issue_arbiter #(
        .N_REQ(N_REQ), .MAX_INFLIGHT(MAX_INFLIGHT), .EU_CTL_LEN(EU_CTL_LEN),
        .XLEN(XLEN), .ROB_IDX_LEN(ROB_IDX_LEN)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_ctl_i(req_ctl_i), .req_rob_idx_i(req_rob_idx_i),
        .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rob_idx_o(rsp_rob_idx_o), .rsp_result_o(rsp_result_o),
        .rsp_except_o(rsp_except_o),
        .mu_valid_o(mu_valid_o), .mu_ready_i(mu_ready_i),
        .mu_ctl_o(mu_ctl_o), .mu_rob_idx_o(mu_rob_idx_o),
        .mu_rs1_o(mu_rs1_o), .mu_rs2_o(mu_rs2_o),
        .mu_valid_i(mu_valid_i), .mu_ready_o(mu_ready_o),
        .mu_rob_idx_i(mu_rob_idx_i), .mu_result_i(mu_result_i),
        .mu_except_i(mu_except_i),
        .mu_flush_o(mu_flush_o)
    );

    // Free-running 10 ns clock.
    always #5 clk_i = ~clk_i;

    // Operand generators: every requester gets distinct values per op_seed,
    // so the ROB index on the MULT bus identifies the granted requester.
    function automatic logic [XLEN-1:0] op_rs1(int seed, int r);
        return XLEN'(seed * 8 + r + 1);
    endfunction

    function automatic logic [XLEN-1:0] op_rs2(int seed, int r);
        return XLEN'(r * 2 + 3 + seed % 5);
    endfunction

    function automatic logic [ROB_IDX_LEN-1:0] op_rob(int seed, int r);
        return ROB_IDX_LEN'(seed * 2 + r);
    endfunction

    function automatic logic [EU_CTL_LEN-1:0] op_ctl(int seed, int r);
        return EU_CTL_LEN'(seed + r);
    endfunction

    // Reference arbitration choice for a given request vector.
    function automatic int model_pick(logic [N_REQ-1:0] valid);
        int idx;
`ifdef MULT_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N_REQ; i++) begin
            if (valid[i]) return i;
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            idx = (model_rr + i) % N_REQ;
            if (valid[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present the current op_seed operands on all requester buses.
    task automatic set_ops();
        for (int r = 0; r < N_REQ; r++) begin
            req_rs1_i[r*XLEN +: XLEN]                   = op_rs1(op_seed, r);
            req_rs2_i[r*XLEN +: XLEN]                   = op_rs2(op_seed, r);
            req_rob_idx_i[r*ROB_IDX_LEN +: ROB_IDX_LEN] = op_rob(op_seed, r);
            req_ctl_i[r*EU_CTL_LEN +: EU_CTL_LEN]       = op_ctl(op_seed, r);
        end
    endtask

    // Record an accepted issue from requester g in the scoreboard.
    task automatic push_issue(int g);
        mres_t m;
        m.rob = op_rob(op_seed, g);
        m.res = op_rs1(op_seed, g) * op_rs2(op_seed, g);
        exp_tag_q.push_back(g);
        mult_q.push_back(m);
        op_seed++;
        model_rr = (g + 1) % N_REQ;
    endtask

    // MULT model output: offer the oldest in-flight result if any.
    task automatic drive_ret();
        if (mult_q.size() > 0) begin
            mu_valid_i   = 1'b1;
            mu_rob_idx_i = mult_q[0].rob;
            mu_result_i  = mult_q[0].res;
            mu_except_i  = mult_q[0].rob[0];
        end else begin
            mu_valid_i   = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i        = 1'b1;
        flush_i      = 1'b0;
        req_valid_i  = '1;
        set_ops();
        mu_ready_i   = 1'b1;
        mu_valid_i   = 1'b1;
        rsp_ready_i  = '1;
        mu_rob_idx_i = 5'd5;
        mu_result_i  = 64'd123;
        mu_except_i  = 1'b1;
        #2;
        n_checks++;
        if (mu_valid_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_mu_valid: got %b expected 0", mu_valid_o);
        end
        n_checks++;
        if (req_ready_o !== 2'b00) begin
            n_fail++; $display("[TB] FAIL reset_req_ready: got %b expected 00", req_ready_o);
        end
        n_checks++;
        if (rsp_valid_o !== 2'b00) begin
            n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b expected 00", rsp_valid_o);
        end
        n_checks++;
        if (mu_ready_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_mu_ready: got %b expected 0", mu_ready_o);
        end
        n_checks++;
        if (mu_rs1_o !== '0 || rsp_result_o !== '0) begin
            n_fail++; $display("[TB] FAIL reset_data: got rs1 %h result %h expected 0", mu_rs1_o, rsp_result_o);
        end
        mu_valid_i = 1'b0;
        tick();
        tick();
        req_valid_i = '0;
        rst_i       = 1'b0;
        #2;
        n_checks++;
        if (mu_valid_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL post_reset_idle: got %b expected 0", mu_valid_o);
        end
        n_checks++;
        if (mu_ready_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL post_reset_empty: got mu_ready %b expected 0", mu_ready_o);
        end
        tick();
    endtask

    // Both requesters active: grants alternate and the fifth op is blocked.
    task automatic test_rr_fairness();
        int g;
        logic [N_REQ-1:0] exp_v;
        req_valid_i = 2'b11;
        mu_ready_i  = 1'b1;
        mu_valid_i  = 1'b0;
        rsp_ready_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            set_ops();
            #2;
            g = model_pick(req_valid_i);
            exp_v = N_REQ'(1 << g);
            n_checks++;
            if (req_ready_o !== exp_v) begin
                n_fail++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", k, req_ready_o, exp_v);
            end
            n_checks++;
            if (mu_rs1_o !== op_rs1(op_seed, g) || mu_rob_idx_o !== op_rob(op_seed, g)) begin
                n_fail++; $display("[TB] FAIL rr_operands[%0d]: got rs1 %h rob %0d expected rs1 %h rob %0d",
                                   k, mu_rs1_o, mu_rob_idx_o, op_rs1(op_seed, g), op_rob(op_seed, g));
            end
            push_issue(g);
            tick();
        end
        set_ops();
        #2;
        n_checks++;
        if (mu_valid_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rr_full_block: got mu_valid %b expected 0", mu_valid_o);
        end
        req_valid_i = '0;
        tick();
    endtask

    // Returns every outstanding result in order and checks routing and data.
    task automatic test_drain();
        int h;
        logic [N_REQ-1:0] exp_v;
        req_valid_i = '0;
        rsp_ready_i = '1;
        mu_ready_i  = 1'b1;
        set_ops();
        for (int k = 0; k < MAX_INFLIGHT + 1 && mult_q.size() > 0; k++) begin
            drive_ret();
            #2;
            h = exp_tag_q[0];
            exp_v = N_REQ'(1 << h);
            n_checks++;
            if (rsp_valid_o !== exp_v || mu_ready_o !== 1'b1) begin
                n_fail++; $display("[TB] FAIL drain_route: got rsp_valid %b mu_ready %b expected %b 1",
                                   rsp_valid_o, mu_ready_o, exp_v);
            end
            n_checks++;
            if (rsp_result_o !== mult_q[0].res || rsp_rob_idx_o !== mult_q[0].rob ||
                rsp_except_o !== mult_q[0].rob[0]) begin
                n_fail++; $display("[TB] FAIL drain_data: got %h/%0d/%b expected %h/%0d/%b",
                                   rsp_result_o, rsp_rob_idx_o, rsp_except_o,
                                   mult_q[0].res, mult_q[0].rob, mult_q[0].rob[0]);
            end
            void'(exp_tag_q.pop_front());
            void'(mult_q.pop_front());
            tick();
        end
        mu_valid_i = 1'b0;
        #2;
        n_checks++;
        if (mu_ready_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL drain_empty: got mu_ready %b expected 0", mu_ready_o);
        end
        tick();
    endtask

    // With no returns, exactly MAX_INFLIGHT issues are accepted; a freed
    // credit is usable only one cycle after the return.
    task automatic test_credit_limit();
        int accepted;
        accepted    = 0;
        req_valid_i = 2'b01;
        mu_ready_i  = 1'b1;
        mu_valid_i  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_ops();
            #2;
            if (req_ready_o[0] === 1'b1) begin
                push_issue(0);
                accepted++;
            end
            tick();
        end
        n_checks++;
        if (accepted !== MAX_INFLIGHT) begin
            n_fail++; $display("[TB] FAIL credit_count: got %0d issues expected %0d", accepted, MAX_INFLIGHT);
        end
        set_ops();
        drive_ret();
        #2;
        n_checks++;
        if (mu_valid_o !== 1'b0 || mu_ready_o !== 1'b1) begin
            n_fail++; $display("[TB] FAIL credit_no_bypass: got mu_valid %b mu_ready %b expected 0 1",
                               mu_valid_o, mu_ready_o);
        end
        void'(exp_tag_q.pop_front());
        void'(mult_q.pop_front());
        tick();
        mu_valid_i = 1'b0;
        set_ops();
        #2;
        n_checks++;
        if (req_ready_o !== 2'b01) begin
            n_fail++; $display("[TB] FAIL credit_resume: got %b expected 01", req_ready_o);
        end
        push_issue(0);
        tick();
        req_valid_i = '0;
    endtask

    // Stall the MULT for 3 cycles: the grant must stay on the first winner
    // even after a higher-ranked requester joins.
    task automatic test_stall_lock();
        int other;
        logic [N_REQ-1:0] exp_v;
        other      = 1 - model_pick(2'b11);
        mu_ready_i = 1'b0;
        mu_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid_i = (k == 0) ? N_REQ'(1 << other) : 2'b11;
            set_ops();
            #2;
            n_checks++;
            if (mu_valid_o !== 1'b1 || req_ready_o !== 2'b00) begin
                n_fail++; $display("[TB] FAIL stall_handshake[%0d]: got mu_valid %b req_ready %b expected 1 00",
                                   k, mu_valid_o, req_ready_o);
            end
            n_checks++;
            if (mu_rob_idx_o !== op_rob(op_seed, other) || mu_rs1_o !== op_rs1(op_seed, other)) begin
                n_fail++; $display("[TB] FAIL stall_lock[%0d]: got rob %0d rs1 %h expected rob %0d rs1 %h",
                                   k, mu_rob_idx_o, mu_rs1_o, op_rob(op_seed, other), op_rs1(op_seed, other));
            end
            tick();
        end
        mu_ready_i = 1'b1;
        set_ops();
        #2;
        exp_v = N_REQ'(1 << other);
        n_checks++;
        if (req_ready_o !== exp_v) begin
            n_fail++; $display("[TB] FAIL stall_accept: got %b expected %b", req_ready_o, exp_v);
        end
        push_issue(other);
        tick();
        req_valid_i = '0;
    endtask

    // Result back-pressure, then a cycle with both issue and return.
    task automatic test_back_to_back();
        int h;
        logic [N_REQ-1:0] exp_v;
        req_valid_i = 2'b01;
        mu_ready_i  = 1'b1;
        mu_valid_i  = 1'b0;
        rsp_ready_i = 2'b11;
        set_ops();
        #2;
        n_checks++;
        if (req_ready_o !== 2'b01) begin
            n_fail++; $display("[TB] FAIL bp_issue: got %b expected 01", req_ready_o);
        end
        push_issue(0);
        tick();
        req_valid_i = '0;
        h = exp_tag_q[0];
        exp_v = N_REQ'(1 << h);
        rsp_ready_i = ~exp_v;
        for (int k = 0; k < 2; k++) begin
            set_ops();
            drive_ret();
            #2;
            n_checks++;
            if (mu_ready_o !== 1'b0 || rsp_valid_o !== exp_v) begin
                n_fail++; $display("[TB] FAIL bp_hold[%0d]: got mu_ready %b rsp_valid %b expected 0 %b",
                                   k, mu_ready_o, rsp_valid_o, exp_v);
            end
            tick();
        end
        rsp_ready_i = 2'b11;
        drive_ret();
        #2;
        n_checks++;
        if (mu_ready_o !== 1'b1 || rsp_result_o !== mult_q[0].res) begin
            n_fail++; $display("[TB] FAIL bp_release: got mu_ready %b result %h expected 1 %h",
                               mu_ready_o, rsp_result_o, mult_q[0].res);
        end
        void'(exp_tag_q.pop_front());
        void'(mult_q.pop_front());
        tick();
        mu_valid_i  = 1'b0;
        req_valid_i = 2'b01;
        for (int k = 0; k < 3; k++) begin
            set_ops();
            #2;
            n_checks++;
            if (req_ready_o !== 2'b01) begin
                n_fail++; $display("[TB] FAIL b2b_fill[%0d]: got %b expected 01", k, req_ready_o);
            end
            push_issue(0);
            tick();
        end
        set_ops();
        drive_ret();
        #2;
        n_checks++;
        if (req_ready_o !== 2'b01 || mu_ready_o !== 1'b1) begin
            n_fail++; $display("[TB] FAIL b2b_both: got req_ready %b mu_ready %b expected 01 1",
                               req_ready_o, mu_ready_o);
        end
        void'(exp_tag_q.pop_front());
        void'(mult_q.pop_front());
        push_issue(0);
        tick();
        mu_valid_i = 1'b0;
        set_ops();
        #2;
        n_checks++;
        if (req_ready_o !== 2'b01) begin
            n_fail++; $display("[TB] FAIL b2b_count_kept: got %b expected 01", req_ready_o);
        end
        push_issue(0);
        tick();
        set_ops();
        #2;
        n_checks++;
        if (mu_valid_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL b2b_full: got mu_valid %b expected 0", mu_valid_o);
        end
        req_valid_i = '0;
        tick();
    endtask

    // Flush with three ops in flight, then normal issue from a clean state.
    task automatic test_flush();
        int g;
        int accepted;
        logic [N_REQ-1:0] exp_v;
        req_valid_i = 2'b11;
        mu_ready_i  = 1'b1;
        mu_valid_i  = 1'b0;
        rsp_ready_i = 2'b11;
        for (int k = 0; k < 3; k++) begin
            set_ops();
            #2;
            g = model_pick(req_valid_i);
            exp_v = N_REQ'(1 << g);
            n_checks++;
            if (req_ready_o !== exp_v) begin
                n_fail++; $display("[TB] FAIL flush_fill[%0d]: got %b expected %b", k, req_ready_o, exp_v);
            end
            push_issue(g);
            tick();
        end
        flush_i = 1'b1;
        set_ops();
        drive_ret();
        #2;
        n_checks++;
        if (mu_valid_o !== 1'b0 || req_ready_o !== 2'b00 || rsp_valid_o !== 2'b00 || mu_ready_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL flush_quiet: got mu_valid %b req_ready %b rsp_valid %b mu_ready %b expected all 0",
                               mu_valid_o, req_ready_o, rsp_valid_o, mu_ready_o);
        end
        n_checks++;
        if (mu_flush_o !== 1'b1) begin
            n_fail++; $display("[TB] FAIL flush_fwd: got %b expected 1", mu_flush_o);
        end
        tick();
        flush_i     = 1'b0;
        mu_valid_i  = 1'b0;
        req_valid_i = '0;
        exp_tag_q.delete();
        mult_q.delete();
        #2;
        n_checks++;
        if (mu_ready_o !== 1'b0 || mu_flush_o !== 1'b0) begin
            n_fail++; $display("[TB] FAIL flush_empty: got mu_ready %b mu_flush %b expected 0 0",
                               mu_ready_o, mu_flush_o);
        end
        tick();
        accepted    = 0;
        req_valid_i = 2'b11;
        for (int k = 0; k < 6; k++) begin
            set_ops();
            #2;
            if (accepted < MAX_INFLIGHT) begin
                g = model_pick(req_valid_i);
                exp_v = N_REQ'(1 << g);
                n_checks++;
                if (req_ready_o !== exp_v) begin
                    n_fail++; $display("[TB] FAIL flush_reissue[%0d]: got %b expected %b", k, req_ready_o, exp_v);
                end
                push_issue(g);
                accepted++;
            end else begin
                n_checks++;
                if (mu_valid_o !== 1'b0) begin
                    n_fail++; $display("[TB] FAIL flush_refull[%0d]: got mu_valid %b expected 0", k, mu_valid_o);
                end
            end
            tick();
        end
        req_valid_i = '0;
    endtask

    // Hard time limit so a wedged run still ends with a failure report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        test_reset();
        test_rr_fairness();
        test_drain();
        test_credit_limit();
        test_drain();
        test_stall_lock();
        test_drain();
        test_back_to_back();
        test_drain();
        test_flush();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
